// File: rtl/l2_block_responder.sv
// Direct-mapped block responder: serves 512-bit blocks to L1, refilling misses from memory in 16 beats.
// Optional BLOCK_RESP_PERF_EN adds saturating hit/miss counters on hit_cnt_o/miss_cnt_o.
module l2_block_responder #(
  parameter int SETS        = 16,
  parameter int HIT_LATENCY = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         req_i,
  input  logic [31:0]  req_addr_i,
  output logic [511:0] data_o,
  output logic [31:0]  addr_o,
  output logic         valid_o,
  output logic         mem_req_o,
  output logic [31:0]  mem_addr_o,
  input  logic         mem_rvalid_i,
  input  logic [31:0]  mem_rdata_i
`ifdef BLOCK_RESP_PERF_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 26 - IDX_W;
  localparam int LAT_W = $clog2(HIT_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEMREQ, FILL, RESPOND} state_t;

  state_t             state_q, state_d;
  logic [25:0]        blk_q, blk_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [3:0]         beat_q, beat_d;
  logic [SETS-1:0]    vbits_q, vbits_d;
  logic               valid_q, valid_d;
  logic [511:0]       data_q, data_d;
  logic [31:0]        addr_q, addr_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;

  logic [31:0]        fill_buf [16];
  logic [511:0]       line_mem [SETS];
  logic [TAG_W-1:0]   tag_mem  [SETS];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               buf_we;
  logic               install;
  logic               lookup_done;
  logic [511:0]       fill_line;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^req_addr_i[5:0];
  assign idx = blk_q[IDX_W-1:0];
  assign tag = blk_q[25:IDX_W];
  assign hit = vbits_q[idx] && (tag_mem[idx] == tag);

  // Final beat bypasses the buffer so the completed line can be installed and returned on one edge.
  always_comb begin
    fill_line = '0;
    for (int j = 0; j < 15; j++) fill_line[32*j +: 32] = fill_buf[j];
    fill_line[511:480] = mem_rdata_i;
  end

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    vbits_d     = vbits_q;
    valid_d     = 1'b0;
    data_d      = '0;
    addr_d      = '0;
    mem_req_d   = 1'b0;
    mem_addr_d  = '0;
    buf_we      = 1'b0;
    install     = 1'b0;
    lookup_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          blk_d   = req_addr_i[31:6];
          lat_d   = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lat_q == LAT_W'(HIT_LATENCY - 1)) begin
          lookup_done = 1'b1;
          if (hit) begin
            state_d = RESPOND;
            valid_d = 1'b1;
            data_d  = line_mem[idx];
            addr_d  = {blk_q, 6'h00};
          end else begin
            state_d    = MEMREQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {blk_q, 6'h00};
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      MEMREQ: begin
        beat_d  = '0;
        state_d = FILL;
      end
      FILL: begin
        if (mem_rvalid_i) begin
          buf_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == 4'd15) begin
            install      = 1'b1;
            vbits_d[idx] = 1'b1;
            state_d      = RESPOND;
            valid_d      = 1'b1;
            data_d       = fill_line;
            addr_d       = {blk_q, 6'h00};
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      lat_q      <= '0;
      beat_q     <= '0;
      vbits_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      vbits_q    <= vbits_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone decide what is meaningful.
  always_ff @(posedge clk_i) begin
    if (buf_we) fill_buf[beat_q] <= mem_rdata_i;
    if (install) begin
      line_mem[idx] <= fill_line;
      tag_mem[idx]  <= tag;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign addr_o     = addr_q;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

`ifdef BLOCK_RESP_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_done) begin
      if (hit) hit_cnt_d  = sat_inc(hit_cnt_q);
      else     miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l2_block_responder.sv
// Directed scoreboard bench for l2_block_responder: expected blocks and burst addresses are queued
// at request time and popped by output monitors.
module tb_l2_block_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_i;
  logic [31:0]  req_addr_i;
  logic [511:0] data_o;
  logic [31:0]  addr_o;
  logic         valid_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;
`ifdef BLOCK_RESP_PERF_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  l2_block_responder dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_i        (req_i),
    .req_addr_i   (req_addr_i),
    .data_o       (data_o),
    .addr_o       (addr_o),
    .valid_o      (valid_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
`ifdef BLOCK_RESP_PERF_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0]  exp_addr_q [$];
  logic [511:0] exp_data_q [$];
  logic [31:0]  exp_mem_q  [$];
  logic [511:0] filled [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (valid_o) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        chk("resp_addr", addr_o, exp_addr_q.pop_front());
        chk("resp_data", data_o, exp_data_q.pop_front());
      end
    end else begin
      chk("idle_addr_zero", addr_o, 0);
      chk("idle_data_zero", data_o, 0);
    end
  end

  // Burst request scoreboard
  always @(negedge clk) begin
    if (mem_req_o) begin
      if (exp_mem_q.size() == 0) chk("unexpected_mem_req", 1, 0);
      else chk("mem_addr", mem_addr_o, exp_mem_q.pop_front());
    end else begin
      chk("idle_mem_addr_zero", mem_addr_o, 0);
    end
  end

  task automatic wait_strobe(input bit want_valid, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (want_valid ? valid_o : mem_req_o) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  // One full request; on a miss the bench plays memory with beats base+j, gap idle cycles between.
  task automatic serve(input logic [31:0] a, input bit miss, input logic [31:0] base,
                       input int gap, input int drop_after);
    logic [511:0] line;
    int acc, at, last;
    bit ok;
    line = '0;
    last = 0;
    for (int j = 0; j < 16; j++) line[32*j +: 32] = base + j;
    if (!miss) line = filled[int'(a[31:6])];
    exp_addr_q.push_back({a[31:6], 6'h00});
    exp_data_q.push_back(line);
    if (miss) exp_mem_q.push_back({a[31:6], 6'h00});
    @(posedge clk); #1;
    req_i = 1'b1;
    req_addr_i = a;
    acc = cyc;
    if (miss) begin
      wait_strobe(1'b0, at, ok);
      chk("mem_req_seen", ok, 1);
      chk("mem_req_latency", at - acc, 3);
      for (int j = 0; j < 16; j++) begin
        @(posedge clk); #1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = base + j;
        last = cyc;
        if (j == drop_after) req_i = 1'b0;
        if (j != 15) begin
          for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'hDEAD_0000 + g;
          end
        end
      end
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      wait_strobe(1'b1, at, ok);
      chk("fill_valid_seen", ok, 1);
      chk("fill_valid_latency", at - last, 1);
      filled[int'(a[31:6])] = line;
    end else begin
      wait_strobe(1'b1, at, ok);
      chk("hit_valid_seen", ok, 1);
      chk("hit_latency", at - acc, 3);
    end
    req_i = 1'b0;
  endtask

  initial begin
    int at;
    bit ok;
    rst_n        = 1'b0;
    req_i        = 1'b0;
    req_addr_i   = '0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_addr", addr_o, 0);
`ifdef BLOCK_RESP_PERF_EN
    chk("rst_hit_cnt", hit_cnt_o, 0);
    chk("rst_miss_cnt", miss_cnt_o, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Cold miss, back-to-back beats
    serve(32'h0000_1040, 1'b1, 32'hA0, 0, -1);
    repeat (2) @(posedge clk);
    // Hit on same block, different offset
    serve(32'h0000_1044, 1'b0, 32'h0, 0, -1);
    // Conflict eviction then re-miss on the evicted block
    serve(32'h0000_1440, 1'b1, 32'hB0, 0, -1);
    serve(32'h0000_1040, 1'b1, 32'hD0, 0, -1);
`ifdef BLOCK_RESP_PERF_EN
    chk("hit_cnt", hit_cnt_o, 1);
    chk("miss_cnt", miss_cnt_o, 3);
`endif

    // Gapped beats with req_i dropped mid-fill; the installed block must then hit
    serve(32'h0000_2080, 1'b1, 32'h100, 2, 5);
    repeat (4) @(posedge clk);
    serve(32'h0000_20BC, 1'b0, 32'h0, 0, -1);
    // Stray beats in IDLE must not disturb anything
    @(posedge clk); #1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5555_5555;
    repeat (3) @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    serve(32'h0000_2080, 1'b0, 32'h0, 0, -1);

    // Reset during a fill after 7 beats, with stray beats across and after reset
    exp_mem_q.push_back(32'h0000_3000);
    @(posedge clk); #1;
    req_i = 1'b1;
    req_addr_i = 32'h0000_3000;
    wait_strobe(1'b0, at, ok);
    chk("rst_fill_mem_req_seen", ok, 1);
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); #1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hE0 + j;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_i = 1'b0;
    mem_rdata_i = 32'hEE;
    @(negedge clk);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_mem_req", mem_req_o, 0);
    chk("midrst_mem_addr", mem_addr_o, 0);
`ifdef BLOCK_RESP_PERF_EN
    chk("midrst_hit_cnt", hit_cnt_o, 0);
`endif
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    serve(32'h0000_1040, 1'b1, 32'hC0, 0, -1);
    serve(32'h0000_2080, 1'b1, 32'h200, 1, -1);

    repeat (5) @(posedge clk);
    chk("resp_queue_drained", exp_addr_q.size(), 0);
    chk("mem_queue_drained", exp_mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
